// File: rtl/vector_pkg.sv
// Shared definitions for the vector display-list writer: word field layout,
// the terminator word and the writer state encoding.
package vector_pkg;

    localparam int POS_BIT    = 0;
    localparam int LINE_BIT   = 1;
    localparam int X_LSB      = 2;
    localparam int Y_LSB      = 10;
    localparam int VEC_WORD_W = 18;

    localparam logic [VEC_WORD_W-1:0] VEC_TERM = '0;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_FILL,
        ST_TERM,
        ST_WAIT_SWAP
    } writer_state_e;

endpackage

// File: rtl/vector_word_pack.sv
// Combinational packing of a move/line command into a display-list word.
// Optional coordinate clamp to [FRAME_MIN, FRAME_MAX] when VECTOR_CLIP_EN is defined.
module vector_word_pack
    import vector_pkg::*;
#(
    parameter int OUT_WIDTH = 8,
    parameter int FRAME_MIN = 0,
    parameter int FRAME_MAX = 255
) (
    input  logic                   line,
    input  logic [OUT_WIDTH-1:0]   x,
    input  logic [OUT_WIDTH-1:0]   y,
    output logic [2*OUT_WIDTH+1:0] word
);

`ifdef VECTOR_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    // Canonical y position for the 8-bit geometry, otherwise packed right after x.
    localparam int Y_POS = (OUT_WIDTH == Y_LSB - X_LSB) ? Y_LSB : X_LSB + OUT_WIDTH;

    // Compared as int so bounds at the edge of the coordinate range stay plain compares.
    function automatic logic [OUT_WIDTH-1:0] clamp(input logic [OUT_WIDTH-1:0] v);
        if (int'(v) < FRAME_MIN) return OUT_WIDTH'(FRAME_MIN);
        if (int'(v) > FRAME_MAX) return OUT_WIDTH'(FRAME_MAX);
        return v;
    endfunction

    logic [OUT_WIDTH-1:0] x_c;
    logic [OUT_WIDTH-1:0] y_c;

    always_comb begin
        x_c = CLIP_EN ? clamp(x) : x;
        y_c = CLIP_EN ? clamp(y) : y;
        word                       = '0;
        word[POS_BIT]              = ~line;
        word[LINE_BIT]             = line;
        word[X_LSB +: OUT_WIDTH]   = x_c;
        word[Y_POS +: OUT_WIDTH]   = y_c;
    end

endmodule

// File: rtl/vector_list_writer.sv
// Double-buffered display-list writer: packs move/line commands into RAM words,
// terminates each frame and swaps banks on frame_done. Optional clip: VECTOR_CLIP_EN.
module vector_list_writer
    import vector_pkg::*;
#(
    parameter int OUT_WIDTH    = 8,
    parameter int ADDRESSWIDTH = 8,
    parameter int DATAWIDTH    = 18,
    parameter int FRAME_MIN    = 0,
    parameter int FRAME_MAX    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_line,
    input  logic [OUT_WIDTH-1:0]    cmd_x,
    input  logic [OUT_WIDTH-1:0]    cmd_y,
    input  logic                    cmd_last,
    input  logic                    frame_done,
    output logic                    wr_en,
    output logic [ADDRESSWIDTH-1:0] wr_addr,
    output logic [DATAWIDTH-1:0]    wr_data,
    output logic                    disp_bank,
    output logic                    overflow,
    output logic [ADDRESSWIDTH-2:0] word_count
);

    localparam int IW = ADDRESSWIDTH - 1;
    localparam logic [IW-1:0] LAST_IDX = '1;

    writer_state_e state_q, state_d;
    logic                    bank_q, bank_d;
    logic                    disp_bank_q, disp_bank_d;
    logic [IW-1:0]           index_q, index_d;
    logic                    overflow_q, overflow_d;
    logic [IW-1:0]           word_count_q, word_count_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDRESSWIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATAWIDTH-1:0]    wr_data_q, wr_data_d;
    logic [DATAWIDTH-1:0]    packed_word;
    logic                    accept;

    vector_word_pack #(
        .OUT_WIDTH (OUT_WIDTH),
        .FRAME_MIN (FRAME_MIN),
        .FRAME_MAX (FRAME_MAX)
    ) u_pack (
        .line (cmd_line),
        .x    (cmd_x),
        .y    (cmd_y),
        .word (packed_word)
    );

    assign cmd_ready = (state_q == ST_FILL);
    assign accept    = cmd_valid & cmd_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        bank_d       = bank_q;
        disp_bank_d  = disp_bank_q;
        index_d      = index_q;
        overflow_d   = overflow_q;
        word_count_d = word_count_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;

        unique case (state_q)
            ST_INIT: begin
                // Give the display an empty list in the bank it reads first.
                wr_en_d   = 1'b1;
                wr_addr_d = {disp_bank_q, {IW{1'b0}}};
                wr_data_d = DATAWIDTH'(VEC_TERM);
                state_d   = ST_FILL;
            end
            ST_FILL: begin
                if (accept) begin
                    if (index_q != LAST_IDX) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = {bank_q, index_q};
                        wr_data_d = packed_word;
                        index_d   = index_q + 1'b1;
                    end else begin
                        // Last slot is kept for the terminator; drop rather than stall.
                        overflow_d = 1'b1;
                    end
                    if (cmd_last) state_d = ST_TERM;
                end
            end
            ST_TERM: begin
                wr_en_d      = 1'b1;
                wr_addr_d    = {bank_q, index_q};
                wr_data_d    = DATAWIDTH'(VEC_TERM);
                word_count_d = index_q;
                state_d      = ST_WAIT_SWAP;
            end
            ST_WAIT_SWAP: begin
                if (frame_done) begin
                    disp_bank_d = bank_q;
                    bank_d      = ~bank_q;
                    index_d     = '0;
                    overflow_d  = 1'b0;
                    state_d     = ST_FILL;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_INIT;
            bank_q       <= 1'b0;
            disp_bank_q  <= 1'b1;
            index_q      <= '0;
            overflow_q   <= 1'b0;
            word_count_q <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
            state_q      <= state_d;
            bank_q       <= bank_d;
            disp_bank_q  <= disp_bank_d;
            index_q      <= index_d;
            overflow_q   <= overflow_d;
            word_count_q <= word_count_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign disp_bank  = disp_bank_q;
    assign overflow   = overflow_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_vector_list_writer.sv
// Directed, table-driven bench for vector_list_writer (frame_done, overflow, clip, async reset).
module tb_vector_list_writer;

    localparam int OW = 8;
    localparam int AW = 8;
    localparam int DW = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_line = 1'b0;
    logic [OW-1:0] cmd_x = '0;
    logic [OW-1:0] cmd_y = '0;
    logic          cmd_last = 1'b0;
    logic          frame_done = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          disp_bank;
    logic          overflow;
    logic [AW-2:0] word_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vector_list_writer #(
        .OUT_WIDTH    (OW),
        .ADDRESSWIDTH (AW),
        .DATAWIDTH    (DW),
        .FRAME_MIN    (16),
        .FRAME_MAX    (240)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_line   (cmd_line),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_last   (cmd_last),
        .frame_done (frame_done),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .disp_bank  (disp_bank),
        .overflow   (overflow),
        .word_count (word_count)
    );

    typedef struct {
        string         name;
        logic          line;
        logic [OW-1:0] x;
        logic [OW-1:0] y;
        logic          last;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " wr_en"},      32'(wr_en),      32'h0);
        check({tag, " wr_addr"},    32'(wr_addr),    32'h0);
        check({tag, " wr_data"},    32'(wr_data),    32'h0);
        check({tag, " disp_bank"},  32'(disp_bank),  32'h1);
        check({tag, " overflow"},   32'(overflow),   32'h0);
        check({tag, " word_count"}, 32'(word_count), 32'h0);
        check({tag, " cmd_ready"},  32'(cmd_ready),  32'h0);
    endtask

    task automatic apply_vec(input vec_t v);
        cmd_valid = 1'b1;
        cmd_line  = v.line;
        cmd_x     = v.x;
        cmd_y     = v.y;
        cmd_last  = v.last;
        step();
        check({v.name, " wr_en"},   32'(wr_en),   32'h1);
        check({v.name, " wr_addr"}, 32'(wr_addr), 32'(v.exp_addr));
        check({v.name, " wr_data"}, 32'(wr_data), 32'(v.exp_data));
    endtask

    task automatic check_term(input string tag, input logic [AW-1:0] addr, input logic [AW-2:0] wc);
        check({tag, " term wr_en"},   32'(wr_en),      32'h1);
        check({tag, " term wr_addr"}, 32'(wr_addr),    32'(addr));
        check({tag, " term wr_data"}, 32'(wr_data),    32'h0);
        check({tag, " word_count"},   32'(word_count), 32'(wc));
    endtask

    initial begin
`ifdef VECTOR_CLIP_EN
        vecs[0] = '{"f1 move(10,20)", 1'b0, 8'd10,  8'd20,  1'b0, 8'h00, 18'h05041};
        vecs[1] = '{"f1 line(200,5)", 1'b1, 8'd200, 8'd5,   1'b1, 8'h01, 18'h04322};
        vecs[2] = '{"f2 line(5,250)", 1'b1, 8'd5,   8'd250, 1'b1, 8'h80, 18'h3C042};
`else
        vecs[0] = '{"f1 move(10,20)", 1'b0, 8'd10,  8'd20,  1'b0, 8'h00, 18'h05029};
        vecs[1] = '{"f1 line(200,5)", 1'b1, 8'd200, 8'd5,   1'b1, 8'h01, 18'h01722};
        vecs[2] = '{"f2 line(5,250)", 1'b1, 8'd5,   8'd250, 1'b1, 8'h80, 18'h3E816};
`endif

        // Reset held across a few edges.
        #23;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b1;
        step();
        check("init wr_en",     32'(wr_en),     32'h1);
        check("init wr_addr",   32'(wr_addr),   32'h80);
        check("init wr_data",   32'(wr_data),   32'h0);
        check("init disp_bank", 32'(disp_bank), 32'h1);
        check("init cmd_ready", 32'(cmd_ready), 32'h1);

        // frame_done while filling is ignored.
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        check("fd in FILL disp_bank", 32'(disp_bank), 32'h1);
        check("fd in FILL wr_en",     32'(wr_en),     32'h0);

        // Frame 1: two commands into bank 0.
        apply_vec(vecs[0]);
        apply_vec(vecs[1]);
        check("TERM cmd_ready", 32'(cmd_ready), 32'h0);
        // frame_done sampled on the edge that enters WAIT_SWAP must not swap.
        frame_done = 1'b1;
        cmd_last   = 1'b0;
        step();
        frame_done = 1'b0;
        check_term("f1", 8'h02, 7'd2);
        check("f1 early fd disp_bank", 32'(disp_bank), 32'h1);
        // Producer keeps offering a command; nothing may be written.
        for (int i = 0; i < 3; i++) begin
            step();
            check("WAIT_SWAP cmd_ready", 32'(cmd_ready), 32'h0);
            check("WAIT_SWAP wr_en",     32'(wr_en),     32'h0);
        end
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        check("swap1 disp_bank", 32'(disp_bank), 32'h0);
        check("swap1 cmd_ready", 32'(cmd_ready), 32'h1);

        // Frame 2: single command into bank 1, also the clip case.
        apply_vec(vecs[2]);
        cmd_valid = 1'b0;
        cmd_last  = 1'b0;
        step();
        check_term("f2", 8'h81, 7'd1);
        step();
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        check("swap2 disp_bank", 32'(disp_bank), 32'h1);

        // Frame 3: 130 commands into bank 0; the last three are dropped.
        for (int i = 0; i < 130; i++) begin
            cmd_valid = 1'b1;
            cmd_line  = 1'b0;
            cmd_x     = OW'(20 + i);
            cmd_y     = 8'd100;
            cmd_last  = (i == 129);
            step();
            if (i < 127) begin
                check("ovf frame wr_en",   32'(wr_en),   32'h1);
                check("ovf frame wr_addr", 32'(wr_addr), 32'(i));
                check("ovf frame wr_data", 32'(wr_data), 32'({8'd100, 8'(20 + i), 2'b01}));
            end else begin
                check("drop wr_en",    32'(wr_en),    32'h0);
                check("drop overflow", 32'(overflow), 32'h1);
            end
        end
        cmd_valid = 1'b0;
        cmd_last  = 1'b0;
        step();
        check_term("f3", 8'h7F, 7'd127);
        check("f3 overflow held", 32'(overflow), 32'h1);
        step();
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        check("swap3 disp_bank", 32'(disp_bank), 32'h0);
        check("swap3 overflow",  32'(overflow),  32'h0);

        // Asynchronous reset between two accepted commands.
        apply_vec('{"pre-reset move(30,40)", 1'b0, 8'd30, 8'd40, 1'b0, 8'h80, 18'h0A079});
        cmd_x = 8'd31;
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("async reset");
        cmd_valid = 1'b0;
        step();
        step();
        check_reset_values("reset held");
        @(negedge clk);
        rst = 1'b1;
        step();
        check("re-init wr_en",     32'(wr_en),     32'h1);
        check("re-init wr_addr",   32'(wr_addr),   32'h80);
        check("re-init wr_data",   32'(wr_data),   32'h0);
        check("re-init disp_bank", 32'(disp_bank), 32'h1);
        check("re-init cmd_ready", 32'(cmd_ready), 32'h1);
        apply_vec('{"post-reset move(50,60)", 1'b0, 8'd50, 8'd60, 1'b0, 8'h00, 18'h0F0C9});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
